// File: rtl/mlaccel_xfer_if.sv
// Buffer/memory transfer bus: command, staging-buffer and memory-request signals.
// The slave modport is the transfer engine's view; master is its environment
// (command FSM, staging buffer and memory arbiter).
interface mlaccel_xfer_if #(
  parameter int unsigned BUF_AW = 9
);
  logic              start;
  logic              dir;
  logic [15:0]       base_addr;
  logic [BUF_AW:0]   count;
  logic              abort;
  logic              busy;
  logic              done;
  logic [BUF_AW:0]   words_done;
  logic [BUF_AW-1:0] buf_addr;
  logic              buf_ren;
  logic [15:0]       buf_rdata;
  logic              buf_wen;
  logic [15:0]       buf_wdata;
  logic              mem_req;
  logic              mem_gnt;
  logic [15:0]       mem_addr;
  logic [1:0]        mem_wen;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;

  modport master (
    output start, dir, base_addr, count, abort, buf_rdata, mem_gnt, mem_rdata,
    input  busy, done, words_done, buf_addr, buf_ren, buf_wen, buf_wdata,
           mem_req, mem_addr, mem_wen, mem_wdata
  );

  modport slave (
    input  start, dir, base_addr, count, abort, buf_rdata, mem_gnt, mem_rdata,
    output busy, done, words_done, buf_addr, buf_ren, buf_wen, buf_wdata,
           mem_req, mem_addr, mem_wen, mem_wdata
  );
endinterface

// File: rtl/mlaccel_xfer.sv
// Word mover between the 512x16 host staging buffer and main memory.
// dir=0 reads the buffer and writes memory; dir=1 reads memory and fills the buffer.
// Every output is a flop whose next value is decoded from the next state.
module mlaccel_xfer #(
  parameter int unsigned BUF_AW = 9
) (
  input logic           clock,
  input logic           resetn,
  mlaccel_xfer_if.slave bus
);
  localparam int unsigned CW = BUF_AW + 1;
  localparam logic [CW-1:0] MaxCount = {1'b1, {BUF_AW{1'b0}}};

  typedef enum logic [2:0] {StIdle, StFetch, StReq, StWait, StWbuf, StDone} state_e;

  state_e            state_q, state_d;
  logic              phase_q, phase_d;   // second cycle of FETCH (capture) or WAIT (data)
  logic              dir_q, dir_d;
  logic [CW-1:0]     count_q, count_d;
  logic [15:0]       cur_addr_q, cur_addr_d;
  logic [BUF_AW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]     words_done_q, words_done_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              buf_ren_q, buf_ren_d;
  logic              buf_wen_q, buf_wen_d;
  logic [BUF_AW-1:0] buf_addr_q, buf_addr_d;
  logic [15:0]       buf_wdata_q, buf_wdata_d;
  logic              mem_req_q, mem_req_d;
  logic [15:0]       mem_addr_q, mem_addr_d;
  logic [1:0]        mem_wen_q, mem_wen_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              last_word;

  assign last_word = (words_done_q + CW'(1)) == count_q;

  // Next state, transfer bookkeeping and registered-output next values
  always_comb begin
    state_d      = state_q;
    phase_d      = 1'b0;
    dir_d        = dir_q;
    count_d      = count_q;
    cur_addr_d   = cur_addr_q;
    ptr_d        = ptr_q;
    words_done_d = words_done_q;
    buf_wdata_d  = buf_wdata_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          dir_d        = bus.dir;
          cur_addr_d   = bus.base_addr;
          count_d      = (bus.count == '0 || bus.count > MaxCount) ? MaxCount : bus.count;
          ptr_d        = '0;
          words_done_d = '0;
          state_d      = bus.dir ? StReq : StFetch;
        end
      end
      StFetch: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          mem_wdata_d = bus.buf_rdata;
          state_d     = StReq;
        end
      end
      StReq: begin
        if (bus.mem_gnt) begin
          if (!dir_q) begin
            words_done_d = words_done_q + CW'(1);
            cur_addr_d   = cur_addr_q + 16'd1;
            if (last_word) begin
              state_d = StDone;
            end else begin
              ptr_d   = ptr_q + BUF_AW'(1);
              state_d = StFetch;
            end
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        // Read data arrives two cycles after the grant
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          buf_wdata_d = bus.mem_rdata;
          state_d     = StWbuf;
        end
      end
      StWbuf: begin
        words_done_d = words_done_q + CW'(1);
        cur_addr_d   = cur_addr_q + 16'd1;
        if (last_word) begin
          state_d = StDone;
        end else begin
          ptr_d   = ptr_q + BUF_AW'(1);
          state_d = StReq;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A write granted in the abort cycle still completes; anything else freezes the count
    if (bus.abort && state_q != StIdle) begin
      state_d = StIdle;
      phase_d = 1'b0;
      if (!(state_q == StReq && bus.mem_gnt && !dir_q)) begin
        words_done_d = words_done_q;
      end
    end

    busy_d     = state_d != StIdle;
    done_d     = state_d == StDone;
    buf_ren_d  = state_d == StFetch && !phase_d;
    buf_wen_d  = state_d == StWbuf;
    mem_req_d  = state_d == StReq;
    buf_addr_d = (buf_ren_d || buf_wen_d) ? ptr_d : buf_addr_q;
    mem_addr_d = mem_req_d ? cur_addr_d : mem_addr_q;
    mem_wen_d  = (mem_req_d && !dir_d) ? 2'b11 : 2'b00;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= StIdle;
      phase_q      <= 1'b0;
      dir_q        <= 1'b0;
      count_q      <= '0;
      cur_addr_q   <= '0;
      ptr_q        <= '0;
      words_done_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      buf_ren_q    <= 1'b0;
      buf_wen_q    <= 1'b0;
      buf_addr_q   <= '0;
      buf_wdata_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wen_q    <= 2'b00;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      dir_q        <= dir_d;
      count_q      <= count_d;
      cur_addr_q   <= cur_addr_d;
      ptr_q        <= ptr_d;
      words_done_q <= words_done_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      buf_ren_q    <= buf_ren_d;
      buf_wen_q    <= buf_wen_d;
      buf_addr_q   <= buf_addr_d;
      buf_wdata_q  <= buf_wdata_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wen_q    <= mem_wen_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.words_done = words_done_q;
  assign bus.buf_addr   = buf_addr_q;
  assign bus.buf_ren    = buf_ren_q;
  assign bus.buf_wen    = buf_wen_q;
  assign bus.buf_wdata  = buf_wdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wen    = mem_wen_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule
